// File: rtl/map_mem_arbiter.sv
// Shares one external-memory port between the mapper's PRG (CPU) and CHR (PPU) accesses.
// It detects access starts on the asynchronous NES bus strobes and gives CHR priority.
// It holds the last read byte of each channel for the cartridge data drivers.
module map_mem_arbiter #(
   parameter int unsigned          ADDR_BITS   = 23,
   parameter logic [ADDR_BITS-1:0] PRG_BASE    = ADDR_BITS'(23'h0),
   parameter logic [ADDR_BITS-1:0] WRAM_BASE   = ADDR_BITS'(23'h7E000),
   parameter logic [ADDR_BITS-1:0] CHR_BASE    = ADDR_BITS'(23'h40000),
   parameter int unsigned          SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 m2,
   input  logic [ADDR_BITS-1:0] prg_addr,
   input  logic                 prg_oe,
   input  logic                 prg_we,
   input  logic                 wram_ce,
   input  logic [7:0]           cpu_wdata,
   input  logic                 ppu_rd_n,
   input  logic                 ppu_wr_n,
   input  logic [ADDR_BITS-1:0] chr_addr,
   input  logic                 chr_ce,
   input  logic                 chr_we,
   input  logic [7:0]           ppu_wdata,
   output logic [7:0]           prg_rdata,
   output logic [7:0]           chr_rdata,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   input  logic                 mem_ack,
   input  logic [7:0]           mem_rdata,
   output logic                 overrun
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                 state_q, state_d;

   logic [SYNC_STAGES-1:0] m2_sync, rd_sync, wr_sync;
   logic                   m2_prev, rd_prev, wr_prev;
   logic                   m2_s, rd_s, wr_s;
   logic                   rd_fall, chr_is_wr;
   logic                   prg_start, chr_start;

   logic                   prg_pend, chr_pend;
   logic                   prg_slot_we, chr_slot_we;
   logic [ADDR_BITS-1:0]   prg_slot_addr, chr_slot_addr;
   logic [7:0]             prg_slot_wdata, chr_slot_wdata;

   logic                   cur_chr, cur_chr_d;
   logic                   req_d, we_d;
   logic [ADDR_BITS-1:0]   addr_d;
   logic [7:0]             wdata_d;
   logic                   issue_prg, issue_chr, ack_done;

   // Strobe synchronizers plus previous-sample registers, reset to idle bus levels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m2_sync <= '0;
         rd_sync <= '1;
         wr_sync <= '1;
         m2_prev <= 1'b0;
         rd_prev <= 1'b1;
         wr_prev <= 1'b1;
      end else begin
         m2_sync <= {m2_sync[SYNC_STAGES-2:0], m2};
         rd_sync <= {rd_sync[SYNC_STAGES-2:0], ppu_rd_n};
         wr_sync <= {wr_sync[SYNC_STAGES-2:0], ppu_wr_n};
         m2_prev <= m2_s;
         rd_prev <= rd_s;
         wr_prev <= wr_s;
      end
   end

   assign m2_s      = m2_sync[SYNC_STAGES-1];
   assign rd_s      = rd_sync[SYNC_STAGES-1];
   assign wr_s      = wr_sync[SYNC_STAGES-1];
   assign rd_fall   = ~rd_s & rd_prev;
   assign chr_is_wr = ~wr_s & wr_prev & chr_we;
   assign prg_start = m2_s & ~m2_prev & (prg_oe | prg_we);
   assign chr_start = chr_ce & (rd_fall | chr_is_wr);

   // Request slots: capture on start, pending until issued; replacing an unissued slot is an overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prg_pend       <= 1'b0;
         chr_pend       <= 1'b0;
         prg_slot_we    <= 1'b0;
         chr_slot_we    <= 1'b0;
         prg_slot_addr  <= '0;
         chr_slot_addr  <= '0;
         prg_slot_wdata <= '0;
         chr_slot_wdata <= '0;
         overrun        <= 1'b0;
      end else begin
         if (prg_start) begin
            prg_slot_we    <= prg_we;
            prg_slot_addr  <= prg_addr + (wram_ce ? WRAM_BASE : PRG_BASE);
            prg_slot_wdata <= cpu_wdata;
         end
         if (chr_start) begin
            chr_slot_we    <= chr_is_wr;
            chr_slot_addr  <= chr_addr + CHR_BASE;
            chr_slot_wdata <= ppu_wdata;
         end
         prg_pend <= prg_start | (prg_pend & ~issue_prg);
         chr_pend <= chr_start | (chr_pend & ~issue_chr);
         overrun  <= overrun
                   | (prg_start & prg_pend & ~issue_prg)
                   | (chr_start & chr_pend & ~issue_chr);
      end
   end

   // Arbiter next state and next memory-port values; CHR wins when both are pending
   always_comb begin
      state_d   = state_q;
      req_d     = mem_req;
      we_d      = mem_we;
      addr_d    = mem_addr;
      wdata_d   = mem_wdata;
      cur_chr_d = cur_chr;
      issue_prg = 1'b0;
      issue_chr = 1'b0;
      ack_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (chr_pend) begin
               issue_chr = 1'b1;
               req_d     = 1'b1;
               we_d      = chr_slot_we;
               addr_d    = chr_slot_addr;
               wdata_d   = chr_slot_wdata;
               cur_chr_d = 1'b1;
               state_d   = BUSY;
            end else if (prg_pend) begin
               issue_prg = 1'b1;
               req_d     = 1'b1;
               we_d      = prg_slot_we;
               addr_d    = prg_slot_addr;
               wdata_d   = prg_slot_wdata;
               cur_chr_d = 1'b0;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack) begin
               req_d    = 1'b0;
               ack_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, memory port and read-data registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cur_chr   <= 1'b0;
         prg_rdata <= '0;
         chr_rdata <= '0;
      end else begin
         state_q   <= state_d;
         mem_req   <= req_d;
         mem_we    <= we_d;
         mem_addr  <= addr_d;
         mem_wdata <= wdata_d;
         cur_chr   <= cur_chr_d;
         if (ack_done && !mem_we) begin
            if (cur_chr) chr_rdata <= mem_rdata;
            else         prg_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Scoreboard bench for map_mem_arbiter: stimulus pushes expected memory transactions,
// a monitor pops and checks them as the DUT issues requests, and a memory model answers.
module tb_map_mem_arbiter;

   localparam int unsigned AW = 23;
   localparam logic [AW-1:0] PRG_B  = 23'h0;
   localparam logic [AW-1:0] WRAM_B = 23'h7E000;
   localparam logic [AW-1:0] CHR_B  = 23'h40000;

   logic          clk, rst_n, m2, prg_oe, prg_we, wram_ce, ppu_rd_n, ppu_wr_n;
   logic          chr_ce, chr_we, mem_req, mem_we, mem_ack, overrun;
   logic [AW-1:0] prg_addr, chr_addr, mem_addr;
   logic [7:0]    cpu_wdata, ppu_wdata, prg_rdata, chr_rdata, mem_wdata, mem_rdata;

   map_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n), .m2(m2), .prg_addr(prg_addr), .prg_oe(prg_oe),
      .prg_we(prg_we), .wram_ce(wram_ce), .cpu_wdata(cpu_wdata), .ppu_rd_n(ppu_rd_n),
      .ppu_wr_n(ppu_wr_n), .chr_addr(chr_addr), .chr_ce(chr_ce), .chr_we(chr_we),
      .ppu_wdata(ppu_wdata), .prg_rdata(prg_rdata), .chr_rdata(chr_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .overrun(overrun)
   );

   typedef struct {
      logic          chr;
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    wdata;
      logic [7:0]    rdata;
   } exp_t;

   exp_t        sbq[$];
   logic [7:0]  ref_mem [logic [AW-1:0]];
   logic [7:0]  ext_mem [logic [AW-1:0]];
   int          checks = 0;
   int          errors = 0;
   int unsigned done_count = 0;
   int unsigned req_count = 0;
   logic        mon_en = 1'b1;
   logic        hold_ack = 1'b0;
   logic        force_ack = 1'b0;
   logic [7:0]  exp_prg = 8'h00;
   logic [7:0]  exp_chr = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] dflt(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]};
   endfunction

   function automatic logic [7:0] ref_val(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic logic [7:0] ext_val(input logic [AW-1:0] a);
      return ext_mem.exists(a) ? ext_mem[a] : dflt(a);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Memory model: acks a request after a random delay, reads/writes its own array
   initial begin
      int unsigned delay_cnt;
      delay_cnt = 0;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hEE;
         end else if (rst_n && mem_req && !hold_ack) begin
            if (delay_cnt == 0) begin
               mem_ack = 1'b1;
               if (mem_we) ext_mem[mem_addr] = mem_wdata;
               else        mem_rdata = ext_val(mem_addr);
               delay_cnt = $urandom_range(0, 3);
            end else begin
               delay_cnt--;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each new request, checks hold and read-data results
   initial begin
      logic          req_active, ack_prev, held_we;
      logic [AW-1:0] held_addr;
      logic [7:0]    held_wdata;
      exp_t          cur;
      req_active = 1'b0;
      ack_prev   = 1'b0;
      held_we    = 1'b0;
      held_addr  = '0;
      held_wdata = '0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            req_active = 1'b0;
            ack_prev   = 1'b0;
         end else begin
            if (ack_prev) begin
               check("req_drop_after_ack", 32'(mem_req), 32'd0);
               check("prg_rdata", 32'(prg_rdata), 32'(exp_prg));
               check("chr_rdata", 32'(chr_rdata), 32'(exp_chr));
               req_active = 1'b0;
               done_count++;
            end
            if (mem_req && !req_active) begin
               req_active = 1'b1;
               req_count++;
               held_we    = mem_we;
               held_addr  = mem_addr;
               held_wdata = mem_wdata;
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_req got addr=%0h we=%0b exp none", mem_addr, mem_we);
               end else begin
                  cur = sbq.pop_front();
                  check("req_we", 32'(mem_we), 32'(cur.we));
                  check("req_addr", 32'(mem_addr), 32'(cur.addr));
                  if (cur.we) check("req_wdata", 32'(mem_wdata), 32'(cur.wdata));
                  else if (cur.chr) exp_chr = cur.rdata;
                  else exp_prg = cur.rdata;
               end
            end else if (mem_req && req_active) begin
               check("hold_req", {8'h00, mem_we, mem_addr}, {8'h00, held_we, held_addr});
               if (held_we) check("hold_wdata", 32'(mem_wdata), 32'(held_wdata));
            end
            ack_prev = mem_ack && mem_req;
         end
      end
   end

   task automatic push_prg(input logic we, input logic wram, input logic [AW-1:0] a,
                           input logic [7:0] d);
      exp_t e;
      logic [AW:0] s;
      s       = {1'b0, a} + {1'b0, (wram ? WRAM_B : PRG_B)};
      e.chr   = 1'b0;
      e.we    = we;
      e.addr  = s[AW-1:0];
      e.wdata = d;
      e.rdata = we ? 8'h00 : ref_val(e.addr);
      if (we) ref_mem[e.addr] = d;
      sbq.push_back(e);
   endtask

   task automatic push_chr(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
      exp_t e;
      logic [AW:0] s;
      s       = {1'b0, a} + {1'b0, CHR_B};
      e.chr   = 1'b1;
      e.we    = we;
      e.addr  = s[AW-1:0];
      e.wdata = d;
      e.rdata = we ? 8'h00 : ref_val(e.addr);
      if (we) ref_mem[e.addr] = d;
      sbq.push_back(e);
   endtask

   task automatic wait_done(input int unsigned target, input string name);
      int n;
      n = 0;
      while (done_count < target && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (done_count < target) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s got done=%0d exp %0d", name, done_count, target);
      end
   endtask

   task automatic wait_req(input string name);
      int n;
      n = 0;
      while (!mem_req && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!mem_req) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s got mem_req=0 exp 1", name);
      end
   endtask

   task automatic prg_op(input logic we, input logic wram, input logic [AW-1:0] a,
                         input logic [7:0] d);
      int unsigned t;
      push_prg(we, wram, a, d);
      t = done_count + 1;
      prg_addr = a; wram_ce = wram; prg_we = we; prg_oe = ~we; cpu_wdata = d;
      @(negedge clk); #1;
      m2 = 1'b1;
      wait_done(t, "prg_op");
      m2 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      prg_oe = 1'b0; prg_we = 1'b0; wram_ce = 1'b0;
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic chr_op(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
      int unsigned t;
      push_chr(we, a, d);
      t = done_count + 1;
      chr_addr = a; chr_ce = 1'b1; chr_we = we; ppu_wdata = d;
      @(negedge clk); #1;
      if (we) ppu_wr_n = 1'b0;
      else    ppu_rd_n = 1'b0;
      wait_done(t, "chr_op");
      ppu_rd_n = 1'b1; ppu_wr_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chr_ce = 1'b0; chr_we = 1'b0;
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic m2_pulse();
      @(negedge clk); #1;
      m2 = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      m2 = 1'b0;
      repeat (4) @(negedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t, rc;
      rst_n = 1'b0; m2 = 1'b0; prg_addr = '0; prg_oe = 1'b0; prg_we = 1'b0; wram_ce = 1'b0;
      cpu_wdata = '0; ppu_rd_n = 1'b1; ppu_wr_n = 1'b1; chr_addr = '0; chr_ce = 1'b0;
      chr_we = 1'b0; ppu_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_prg_rdata", 32'(prg_rdata), 32'd0);
      check("rst_chr_rdata", 32'(chr_rdata), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // PRG read returning 0xA5, then a WRAM write that must not disturb prg_rdata
      ref_mem[23'h1234] = 8'hA5;
      ext_mem[23'h1234] = 8'hA5;
      prg_op(1'b0, 1'b0, 23'h1234, 8'h00);
      check("prg_read_a5", 32'(prg_rdata), 32'hA5);
      prg_op(1'b1, 1'b1, 23'h0010, 8'h3C);
      check("wram_write_keeps_rdata", 32'(prg_rdata), 32'hA5);

      // Randomized single transactions on both channels
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: prg_op(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom));
            1: prg_op(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom));
            2: chr_op(1'b0, AW'($urandom), 8'($urandom));
            default: chr_op(1'b1, AW'($urandom), 8'($urandom));
         endcase
      end

      // CHR address that wraps past the top of memory
      chr_op(1'b0, 23'h7FFFFF, 8'h00);

      // Starts that must not produce any request
      rc = req_count;
      chr_addr = 23'h0123; chr_ce = 1'b0; chr_we = 1'b1;
      @(negedge clk); #1;
      ppu_rd_n = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      ppu_rd_n = 1'b1; chr_ce = 1'b1; chr_we = 1'b0;
      @(negedge clk); #1;
      ppu_wr_n = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      ppu_wr_n = 1'b1; chr_ce = 1'b0;
      prg_oe = 1'b0; prg_we = 1'b0;
      m2_pulse();
      repeat (4) @(negedge clk);
      #1;
      check("no_req_count", req_count, rc);
      check("no_req_level", 32'(mem_req), 32'd0);

      // Simultaneous starts: CHR first, PRG one idle cycle after its ack
      push_chr(1'b0, 23'h0800, 8'h00);
      push_prg(1'b0, 1'b0, 23'h0200, 8'h00);
      t = done_count + 1;
      chr_addr = 23'h0800; chr_ce = 1'b1; chr_we = 1'b0;
      prg_addr = 23'h0200; prg_oe = 1'b1;
      @(negedge clk); #1;
      m2 = 1'b1; ppu_rd_n = 1'b0;
      wait_done(t, "collision_chr");
      @(negedge clk); #1;
      check("b2b_gap_req", 32'(mem_req), 32'd1);
      check("b2b_prg_addr", 32'(mem_addr), 32'h0200);
      wait_done(t + 1, "collision_prg");
      m2 = 1'b0; ppu_rd_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chr_ce = 1'b0; prg_oe = 1'b0;

      // New PRG start while a PRG request is in flight: queued, no overrun
      hold_ack = 1'b1;
      t = done_count + 2;
      push_prg(1'b0, 1'b0, 23'h0300, 8'h00);
      prg_addr = 23'h0300; prg_oe = 1'b1;
      @(negedge clk); #1;
      m2 = 1'b1;
      wait_req("inflight_first");
      m2 = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      push_prg(1'b0, 1'b0, 23'h0304, 8'h00);
      prg_addr = 23'h0304;
      m2_pulse();
      hold_ack = 1'b0;
      wait_done(t, "inflight");
      prg_oe = 1'b0;
      check("inflight_no_overrun", 32'(overrun), 32'd0);

      // Two PRG starts while CHR is stuck: second replaces first, overrun set
      hold_ack = 1'b1;
      t = done_count + 2;
      push_chr(1'b0, 23'h0900, 8'h00);
      chr_addr = 23'h0900; chr_ce = 1'b1;
      @(negedge clk); #1;
      ppu_rd_n = 1'b0;
      wait_req("overrun_chr");
      prg_oe = 1'b1; prg_addr = 23'h0400;
      m2_pulse();
      check("overrun_after_one", 32'(overrun), 32'd0);
      push_prg(1'b0, 1'b0, 23'h0500, 8'h00);
      prg_addr = 23'h0500;
      m2_pulse();
      check("overrun_set", 32'(overrun), 32'd1);
      hold_ack = 1'b0;
      wait_done(t, "overrun");
      ppu_rd_n = 1'b1; prg_oe = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chr_ce = 1'b0;
      check("overrun_sticky", 32'(overrun), 32'd1);
      check("overrun_queue_empty", sbq.size(), 0);

      // Reset in the middle of a transaction, then a late ack that must be ignored
      hold_ack = 1'b1;
      push_prg(1'b0, 1'b0, 23'h0600, 8'h00);
      prg_addr = 23'h0600; prg_oe = 1'b1;
      @(negedge clk); #1;
      m2 = 1'b1;
      wait_req("reset_req");
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_req", 32'(mem_req), 32'd0);
      check("async_rst_prg_rdata", 32'(prg_rdata), 32'd0);
      check("async_rst_chr_rdata", 32'(chr_rdata), 32'd0);
      check("async_rst_overrun", 32'(overrun), 32'd0);
      m2 = 1'b0; prg_oe = 1'b0; hold_ack = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      force_ack = 1'b1;
      @(posedge clk);
      #2 force_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("late_ack_req", 32'(mem_req), 32'd0);
      check("late_ack_prg_rdata", 32'(prg_rdata), 32'd0);
      check("late_ack_chr_rdata", 32'(chr_rdata), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
